// File: rtl/serial_frame_loader.sv
// ---------------------------------------------------------------------------
// serial_frame_loader
//   Input stage of the XOR stream-cipher datapath. Two framed serial streams
//   share one data pin: a KEY_W-bit key frame (key_en) and an MSG_W-bit
//   message frame (msg_en), both shifted in MSB-first, one bit per clock.
//   The last completed key is held on key_out. Each completed message is
//   offered to the cipher core over a valid/ready handshake. Short frames,
//   conflicting enables and dropped messages are flagged with one-cycle pulses.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active high
//   ser_in       serial data bit
//   key_en       key frame enable
//   msg_en       message frame enable
//   key_out      last completed key
//   key_valid    sticky, set once any key frame has completed
//   msg_out      completed message, stable while msg_valid is high
//   msg_valid    message handshake valid
//   msg_ready    core accepts msg_out
//   busy         high while a frame is being shifted in
//   frame_err    pulse: short frame or conflicting enables
//   overrun_err  pulse: completed message dropped, previous one still pending
// ---------------------------------------------------------------------------
module serial_frame_loader #(
  parameter int KEY_W = 8,
  parameter int MSG_W = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             key_en,
  input  logic             msg_en,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic [MSG_W-1:0] msg_out,
  output logic             msg_valid,
  input  logic             msg_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_KEY = 2'd1,
    LOAD_MSG = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  // One bit short of a message: the bit arriving on the completing edge is
  // appended combinationally, so the frame is captured on that same edge.
  logic [MSG_W-2:0]   r_shift;
  // Which enable DRAIN is waiting on (1 = key frame just completed).
  logic               r_drain_key;
  // Cleared by any enable conflict; a new frame may only start once both
  // enables have been observed low in IDLE. Also cleared by reset so the tail
  // of an interrupted frame is never mistaken for the start of a new one.
  logic               r_armed;

  logic [MSG_W-1:0]   w_frame;
  logic               w_is_key;
  logic               w_own_en;
  logic               w_oth_en;
  logic [CNT_W-1:0]   w_len;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_start;
  logic               w_shift;
  logic               w_key_done;
  logic               w_msg_done;
  logic               w_ferr;
  logic               w_armed_nxt;
  logic               w_drain_key_nxt;

  assign w_frame = {r_shift, ser_in};
  assign busy    = (r_state == LOAD_KEY) || (r_state == LOAD_MSG);

  // -------------------------------------------------------------------------
  // Next-state / control
  // -------------------------------------------------------------------------
  always_comb begin
    w_is_key        = (r_state == LOAD_KEY) || ((r_state == DRAIN) && r_drain_key);
    w_own_en        = w_is_key ? key_en : msg_en;
    w_oth_en        = w_is_key ? msg_en : key_en;
    w_len           = w_is_key ? CNT_W'(KEY_W) : CNT_W'(MSG_W);
    w_cnt_inc       = r_cnt + 1'b1;
    w_state_nxt     = r_state;
    w_start         = 1'b0;
    w_shift         = 1'b0;
    w_key_done      = 1'b0;
    w_msg_done      = 1'b0;
    w_ferr          = 1'b0;
    w_armed_nxt     = r_armed;
    w_drain_key_nxt = r_drain_key;

    unique case (r_state)
      IDLE: begin
        if (!key_en && !msg_en) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          if (key_en && msg_en) begin
            // Reported once; further both-high cycles wait for the re-arm.
            w_ferr      = 1'b1;
            w_armed_nxt = 1'b0;
          end else begin
            w_start     = 1'b1;
            w_shift     = 1'b1;
            w_state_nxt = key_en ? LOAD_KEY : LOAD_MSG;
          end
        end
      end

      LOAD_KEY, LOAD_MSG: begin
        if (w_oth_en) begin
          w_ferr      = 1'b1;
          w_armed_nxt = 1'b0;
          w_state_nxt = IDLE;
        end else if (!w_own_en) begin
          w_ferr      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_shift = 1'b1;
          if (w_cnt_inc == w_len) begin
            w_key_done      = (r_state == LOAD_KEY);
            w_msg_done      = (r_state == LOAD_MSG);
            w_drain_key_nxt = (r_state == LOAD_KEY);
            w_state_nxt     = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Trailing bits are ignored; the other enable only disarms.
        if (w_oth_en) w_armed_nxt = 1'b0;
        if (!w_own_en) w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, datapath and outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_drain_key <= 1'b0;
      r_armed     <= 1'b0;
      key_out     <= '0;
      key_valid   <= 1'b0;
      msg_out     <= '0;
      msg_valid   <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_armed     <= w_armed_nxt;
      r_drain_key <= w_drain_key_nxt;
      frame_err   <= w_ferr;
      overrun_err <= 1'b0;

      // Counter stops at the frame length because completion leaves LOAD.
      if (w_start)                  r_cnt <= CNT_W'(1);
      else if (w_shift)             r_cnt <= w_cnt_inc;
      else if (w_state_nxt == IDLE) r_cnt <= '0;

      if (w_shift) r_shift <= w_frame[MSG_W-2:0];

      if (w_key_done) begin
        key_out   <= w_frame[KEY_W-1:0];
        key_valid <= 1'b1;
      end

      if (msg_valid && msg_ready) msg_valid <= 1'b0;

      // A message completing on the acceptance edge replaces the old one.
      if (w_msg_done) begin
        if (!msg_valid || msg_ready) begin
          msg_out   <= w_frame;
          msg_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_loader.sv
module tb_serial_frame_loader;
  localparam int KEY_W = 8;
  localparam int MSG_W = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             ser_in, key_en, msg_en, msg_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic [MSG_W-1:0] msg_out;
  logic             msg_valid, busy, frame_err, overrun_err;

  always #5 clk = ~clk;

  serial_frame_loader #(.KEY_W(KEY_W), .MSG_W(MSG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .key_en(key_en), .msg_en(msg_en),
    .key_out(key_out), .key_valid(key_valid), .msg_out(msg_out),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .busy(busy),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: messages the core should receive, in order, plus
  // outstanding error pulses and the key the loader should be holding.
  logic [MSG_W-1:0] sb_q[$];
  int               ferr_exp = 0;
  int               ovr_exp  = 0;
  logic [KEY_W-1:0] exp_key  = '0;
  logic             exp_kv   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes accepted messages and error pulses from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (msg_valid && msg_ready) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL msg_accept unexpected actual=%h expected=none", msg_out);
          end else begin
            chk("msg_accept", msg_out, sb_q.pop_front());
          end
        end
        if (frame_err) begin
          checks++;
          if (ferr_exp > 0) ferr_exp--;
          else begin errors++; $display("FAIL frame_err actual=1 expected=0"); end
        end
        if (overrun_err) begin
          checks++;
          if (ovr_exp > 0) ovr_exp--;
          else begin errors++; $display("FAIL overrun_err actual=1 expected=0"); end
        end
      end
    end
  end

  // One framed transfer. nbits < frame length gives a short frame; other_at>=0
  // raises the other enable at that bit index; extra trailing bits follow a
  // complete frame.
  task automatic run_frame(input bit is_key, input logic [63:0] data, input int nbits,
                           input int extra, input int other_at, input bit rdy);
    int len;
    bit full, ovr, oth;
    len  = is_key ? KEY_W : MSG_W;
    full = (nbits >= len) && (other_at < 0);
    ovr  = 1'b0;
    msg_ready = rdy;
    if (!full) ferr_exp++;
    else if (!is_key) begin
      ovr = !rdy && (sb_q.size() > 0);
      if (ovr) ovr_exp++;
      else sb_q.push_back(data);
    end
    for (int i = 0; i < nbits + extra; i++) begin
      oth    = (other_at >= 0) && (i >= other_at);
      key_en = is_key ? 1'b1 : oth;
      msg_en = is_key ? oth : 1'b1;
      ser_in = (i < len) ? data[len-1-i] : 1'($urandom);
      if (i == len - 1 && full && is_key) chk("key_before_last", key_out, exp_key);
      tick();
      if (i == 0) chk("busy_in_frame", busy, 1);
      if (other_at >= 0 && i == other_at) break;
      if (i == len - 1 && full) begin
        if (is_key) begin
          exp_key = data[KEY_W-1:0];
          exp_kv  = 1'b1;
          chk("key_out_at_done", key_out, exp_key);
          chk("key_valid_at_done", key_valid, 1);
        end else if (ovr) begin
          chk("msg_valid_on_overrun", msg_valid, 1);
          chk("msg_hold_on_overrun", msg_out, sb_q[0]);
        end else begin
          chk("msg_valid_at_done", msg_valid, 1);
          chk("msg_out_at_done", msg_out, data);
        end
      end
    end
    key_en = 1'b0;
    msg_en = 1'b0;
    tick();
    tick();
    chk("busy_idle", busy, 0);
    chk("key_out_after", key_out, exp_key);
    chk("key_valid_after", key_valid, exp_kv);
  endtask

  task automatic conflict();
    ferr_exp++;
    key_en = 1'b1; msg_en = 1'b1; ser_in = 1'b1;
    tick();
    chk("busy_conflict", busy, 0);
    key_en = 1'b0; msg_en = 1'b0;
    tick();
    tick();
    chk("key_out_conflict", key_out, exp_key);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ser_in = 1'b0; key_en = 1'b0; msg_en = 1'b0; msg_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_key_out", key_out, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_msg_out", msg_out, 0);
    chk("rst_msg_valid", msg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {frame_err, overrun_err}, 0);
    repeat (2) tick();

    // Directed scenarios.
    run_frame(1'b1, 64'hA5, 8, 0, -1, 1'b0);
    run_frame(1'b0, 64'hA3B1F9D2E7C6A594, 64, 0, -1, 1'b0);
    tick();
    chk("msg_valid_hold", msg_valid, 1);
    chk("msg_out_hold", msg_out, 64'hA3B1F9D2E7C6A594);
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    chk("msg_valid_after_accept", msg_valid, 0);

    run_frame(1'b0, {$urandom, $urandom}, 40, 0, -1, 1'b0);
    chk("msg_valid_short", msg_valid, 0);

    run_frame(1'b0, 64'h0123456789ABCDEF, 64, 0, -1, 1'b0);
    run_frame(1'b0, 64'hFFFFFFFFFFFFFFFF, 64, 0, -1, 1'b0);
    chk("msg_out_after_overrun", msg_out, 64'h0123456789ABCDEF);
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;

    conflict();
    chk("key_out_unchanged_A5", key_out, 64'hA5);
    run_frame(1'b1, 64'h3C, 8, 4, -1, 1'b0);

    // Reset in the middle of a message frame.
    msg_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      msg_en = 1'b1; ser_in = 1'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; msg_en = 1'b0;
    sb_q.delete();
    exp_key = '0; exp_kv = 1'b0;
    chk("mid_rst_key_out", key_out, 0);
    chk("mid_rst_key_valid", key_valid, 0);
    chk("mid_rst_msg_out", msg_out, 0);
    chk("mid_rst_msg_valid", msg_valid, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    run_frame(1'b1, 64'h5A, 8, 0, -1, 1'b0);
    run_frame(1'b0, 64'hA3B1F9D2E7C6A594, 64, 0, -1, 1'b1);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      bit isk;
      int kind, len, nb, ex, oa;
      isk  = 1'($urandom);
      len  = isk ? KEY_W : MSG_W;
      kind = int'($urandom_range(0, 4));
      nb   = (kind == 2) ? int'($urandom_range(1, len - 1)) : len;
      ex   = (kind == 1) ? int'($urandom_range(1, 5)) : 0;
      oa   = (kind == 3) ? int'($urandom_range(1, len - 1)) : -1;
      if (kind == 4) conflict();
      else run_frame(isk, {$urandom, $urandom}, nb, ex, oa, 1'($urandom));
    end

    msg_ready = 1'b1;
    repeat (4) tick();
    chk("sb_empty", sb_q.size(), 0);
    chk("frame_err_outstanding", ferr_exp, 0);
    chk("overrun_outstanding", ovr_exp, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
